// File: rtl/recv_buffer_pkg.sv
// Shared sizes, Avalon address decode fields and status word layout for the
// receive buffer.
package recv_buffer_pkg;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CH_W   = $clog2(NUM_CH);

    // address[5] picks data/status, address[4:3] picks the channel
    localparam int unsigned ADDR_SEL_BIT = 5;
    localparam int unsigned CH_LSB       = 3;

    localparam int unsigned ST_EMPTY_LSB = 0;
    localparam int unsigned ST_FULL_LSB  = 4;
    localparam int unsigned ST_OVF_LSB   = 8;
    localparam int unsigned ST_UDR_LSB   = 12;
    localparam int unsigned ST_CNT_LSB   = 16;

    // Build the status word; unlisted bits read as zero.
    function automatic logic [DATA_W-1:0] pack_status(
        input logic [NUM_CH-1:0]       empty,
        input logic [NUM_CH-1:0]       full,
        input logic [NUM_CH-1:0]       overflow,
        input logic [NUM_CH-1:0]       underrun,
        input logic [NUM_CH*CNT_W-1:0] counts
    );
        logic [DATA_W-1:0] st;
        st = '0;
        st[ST_EMPTY_LSB +: NUM_CH]     = empty;
        st[ST_FULL_LSB  +: NUM_CH]     = full;
        st[ST_OVF_LSB   +: NUM_CH]     = overflow;
        st[ST_UDR_LSB   +: NUM_CH]     = underrun;
        st[ST_CNT_LSB +: NUM_CH*CNT_W] = counts;
        return st;
    endfunction

endpackage

// File: rtl/recv_buffer_if.sv
// Avalon-MM read slave plus RDMA push side of the receive buffer.
interface recv_buffer_if;
    import recv_buffer_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              clken;
    logic              chipselect;
    logic              read;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    logic [DATA_W-1:0] dataIn;
    logic              dataPush;
    logic [CH_W-1:0]   dataChannel;
    logic [NUM_CH-1:0] fullArray;
    logic [NUM_CH-1:0] emptyArray;
    logic              dataAvail;

    modport master (
        output address, clken, chipselect, read, dataIn, dataPush, dataChannel,
        input  readdata, readdatavalid, fullArray, emptyArray, dataAvail
    );

    modport slave (
        input  address, clken, chipselect, read, dataIn, dataPush, dataChannel,
        output readdata, readdatavalid, fullArray, emptyArray, dataAvail
    );

endinterface

// File: rtl/recv_chan_fifo.sv
// One receive channel: circular storage with registered count, full and empty.
module recv_chan_fifo
    import recv_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              push_ok;
    logic              pop_ok;

    // full/empty are pre-cycle qualifiers, so a full channel drops a push
    // even when a pop frees a slot in the same cycle
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/recv_buffer.sv
// Per-channel receive FIFOs filled by the RDMA engine and drained by
// memory-mapped reads from the PCIe BAR slave.
module recv_buffer
    import recv_buffer_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    recv_buffer_if.slave bus
);

    logic                    rd;
    logic                    rd_data;
    logic                    rd_stat;
    logic [CH_W-1:0]         rd_ch;
    logic [NUM_CH-1:0]       push_sel;
    logic [NUM_CH-1:0]       pop_sel;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       empty;
    logic [NUM_CH*CNT_W-1:0] counts;
    logic [DATA_W-1:0]       head [NUM_CH];
    logic [NUM_CH-1:0]       overflow;
    logic [NUM_CH-1:0]       underrun;
    logic [NUM_CH-1:0]       ovf_set;
    logic [NUM_CH-1:0]       udr_set;
    logic [DATA_W-1:0]       status;
    logic                    unused_addr;

    assign rd      = bus.chipselect & bus.read & bus.clken;
    assign rd_stat = rd & bus.address[ADDR_SEL_BIT];
    assign rd_data = rd & ~bus.address[ADDR_SEL_BIT];
    assign rd_ch   = bus.address[CH_LSB +: CH_W];

    assign unused_addr = ^{bus.address[ADDR_W-1:ADDR_SEL_BIT+1], bus.address[CH_LSB-1:0]};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push_sel[c] = bus.dataPush & (bus.dataChannel == CH_W'(c));
        assign pop_sel[c]  = rd_data & (rd_ch == CH_W'(c)) & ~empty[c];

        recv_chan_fifo u_fifo (
            .clk   (clock),
            .rst   (reset),
            .push  (push_sel[c]),
            .pop   (pop_sel[c]),
            .din   (bus.dataIn),
            .head  (head[c]),
            .full  (full[c]),
            .empty (empty[c]),
            .count (counts[c*CNT_W +: CNT_W])
        );
    end

    // Sticky event sources, judged on pre-cycle full/empty
    always_comb begin
        ovf_set = '0;
        udr_set = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ovf_set[c] = push_sel[c] & full[c];
            udr_set[c] = rd_data & (rd_ch == CH_W'(c)) & empty[c];
        end
    end

    assign status = pack_status(empty, full, overflow, underrun, counts);

    // Read response and stickies; a same-cycle event outlives a status clear
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
            overflow          <= '0;
            underrun          <= '0;
        end else begin
            bus.readdatavalid <= rd;
            if (rd_stat) begin
                bus.readdata <= status;
            end else if (rd_data) begin
                bus.readdata <= empty[rd_ch] ? '0 : head[rd_ch];
            end
            overflow <= (rd_stat ? '0 : overflow) | ovf_set;
            underrun <= (rd_stat ? '0 : underrun) | udr_set;
        end
    end

    assign bus.fullArray  = full;
    assign bus.emptyArray = empty;
    assign bus.dataAvail  = ~&empty;

endmodule

// File: tb/tb_recv_buffer.sv
// Scoreboard bench for recv_buffer: a queue-based channel model predicts each
// read response and the flag outputs.
module tb_recv_buffer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    recv_buffer_if bus ();

    recv_buffer dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic [255:0] sb [$];
    logic [255:0] mq [4][$];
    logic [3:0]   m_ovf;
    logic [3:0]   m_udr;
    logic         pend;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_status();
        logic [255:0] st;
        st = '0;
        for (int c = 0; c < 4; c++) begin
            st[c]      = (mq[c].size() == 0);
            st[4 + c]  = (mq[c].size() == 8);
            st[16 + 4*c +: 4] = 4'(mq[c].size());
        end
        st[11:8]  = m_ovf;
        st[15:12] = m_udr;
        return st;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    // One clock: update the model from pre-cycle state, drive, step, check flags.
    task automatic cycle(input logic rst, input logic push, input logic [1:0] pch,
                         input logic [255:0] pdata, input logic rd, input logic ce,
                         input logic [9:0] addr);
        logic       rd_acc;
        logic       full_pre;
        logic [1:0] rch;
        logic [3:0] o_set;
        logic [3:0] u_set;
        logic [8:0] flags;
        rch    = addr[4:3];
        rd_acc = rd & ce & ~rst;
        o_set  = '0;
        u_set  = '0;
        if (rst) begin
            for (int c = 0; c < 4; c++) mq[c].delete();
            m_ovf = '0;
            m_udr = '0;
        end else begin
            full_pre = (mq[pch].size() == 8);
            if (rd_acc) begin
                if (addr[5]) sb.push_back(model_status());
                else if (mq[rch].size() == 0) begin
                    sb.push_back('0);
                    u_set[rch] = 1'b1;
                end else sb.push_back(mq[rch].pop_front());
            end
            if (push) begin
                if (full_pre) o_set[pch] = 1'b1;
                else mq[pch].push_back(pdata);
            end
            m_ovf = ((rd_acc && addr[5]) ? 4'h0 : m_ovf) | o_set;
            m_udr = ((rd_acc && addr[5]) ? 4'h0 : m_udr) | u_set;
        end
        reset           = rst;
        bus.dataPush    = push;
        bus.dataChannel = pch;
        bus.dataIn      = pdata;
        bus.read        = rd;
        bus.chipselect  = rd;
        bus.clken       = ce;
        bus.address     = addr;
        @(posedge clk);
        #1;
        flags = '0;
        for (int c = 0; c < 4; c++) begin
            flags[c]     = (mq[c].size() == 0);
            flags[4 + c] = (mq[c].size() == 8);
        end
        flags[8] = ~&flags[3:0];
        check("flags", 256'({bus.dataAvail, bus.fullArray, bus.emptyArray}), 256'(flags));
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1, 10'h0);
    endtask

    task automatic push_beat(input logic [1:0] ch, input logic [255:0] d);
        cycle(1'b0, 1'b1, ch, d, 1'b0, 1'b1, 10'h0);
    endtask

    task automatic read_data(input logic [1:0] ch);
        cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, {5'd0, 1'b0, ch, 2'b00});
    endtask

    task automatic read_stat();
        cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b1, 10'h020);
    endtask

    // Response monitor: readdatavalid exactly one cycle after each accepted read
    initial begin
        forever begin
            @(posedge clk);
            pend = bus.chipselect & bus.read & bus.clken & ~reset;
            @(negedge clk);
            check("rdvalid", 256'(bus.readdatavalid), 256'(pend));
            if (bus.readdatavalid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rdata: response with no expected entry, got %h", bus.readdata);
                end else begin
                    check("rdata", bus.readdata, sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [255:0] d;
        reset           = 1'b1;
        bus.dataPush    = 1'b0;
        bus.dataChannel = '0;
        bus.dataIn      = '0;
        bus.read        = 1'b0;
        bus.chipselect  = 1'b0;
        bus.clken       = 1'b1;
        bus.address     = '0;
        m_ovf = '0;
        m_udr = '0;

        cycle(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 10'h0);
        cycle(1'b1, 1'b0, 2'd0, '0, 1'b0, 1'b1, 10'h0);
        check("reset_rdata", bus.readdata, '0);
        read_stat();
        idle();

        // Three beats through channel 2, read back in order
        for (int i = 1; i <= 3; i++) push_beat(2'd2, {8{32'hA000_0000 + 32'(i)}});
        for (int i = 0; i < 3; i++) read_data(2'd2);
        idle();

        // Fill channel 0 and overflow it; status clears the sticky
        for (int i = 0; i < 9; i++) push_beat(2'd0, rnd256());
        read_stat();
        read_stat();

        // Underrun on empty channel 1
        read_data(2'd1);
        read_stat();

        // Channel 3: simultaneous push and pop, non-empty then empty
        for (int i = 0; i < 4; i++) push_beat(2'd3, rnd256());
        cycle(1'b0, 1'b1, 2'd3, rnd256(), 1'b1, 1'b1, 10'h018);
        read_stat();
        for (int i = 0; i < 4; i++) read_data(2'd3);
        cycle(1'b0, 1'b1, 2'd3, rnd256(), 1'b1, 1'b1, 10'h018);
        read_stat();

        // Push to full channel 0 while popping it: push is still dropped
        cycle(1'b0, 1'b1, 2'd0, rnd256(), 1'b1, 1'b1, 10'h000);
        read_stat();

        // Read with clken low is ignored
        cycle(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0, 10'h008);
        idle();

        // Reset mid-stream, with a read in the reset cycle
        for (int i = 0; i < 5; i++) push_beat(2'd1, rnd256());
        cycle(1'b1, 1'b0, 2'd0, '0, 1'b1, 1'b1, 10'h008);
        idle();
        read_data(2'd1);
        read_stat();
        idle();

        // Random mixed traffic
        for (int i = 0; i < 400; i++) begin
            d = rnd256();
            if ($urandom_range(0, 3) == 0)
                cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
                      1'b1, 1'($urandom_range(0, 7) != 0), 10'h020);
            else
                cycle(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), d,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
                      {5'd0, 1'b0, 2'($urandom_range(0, 3)), 2'b00});
        end
        read_stat();
        idle();
        idle();
        check("sb_drained", 256'(sb.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
